// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg
//   Shared definitions for the SPI slave controller: register offsets,
//   CTRL/STATUS bit positions, reset values, the register-select enum and
//   a helper that builds the RX word-length mask.
//   No ports (package).
package spi_slave_ctrl_pkg;

  // Register byte offsets inside the window
  localparam int unsigned REG_CTRL   = 32'h0;
  localparam int unsigned REG_STATUS = 32'h4;
  localparam int unsigned REG_TXDATA = 32'h8;
  localparam int unsigned REG_RXDATA = 32'hC;

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_CPOLPHA_LSB = 1;
  localparam int CTRL_LEN_LSB     = 3;
  localparam int CTRL_IE_RX       = 7;
  localparam int CTRL_IE_TXE      = 8;
  localparam int CTRL_IE_ERR      = 9;
  localparam int CTRL_W           = 10;

  // STATUS bit positions
  localparam int ST_RX_COUNT_LSB = 0;
  localparam int ST_TX_COUNT_LSB = 5;
  localparam int ST_RX_EMPTY     = 10;
  localparam int ST_RX_FULL      = 11;
  localparam int ST_TX_EMPTY     = 12;
  localparam int ST_TX_FULL      = 13;
  localparam int ST_RX_OVF       = 14;
  localparam int ST_TX_UNF       = 15;

  // FIFO occupancy counters are 5 bits wide, which caps DEPTH at 16
  localparam int CNT_W = 5;

  localparam logic [3:0] LEN_RESET     = 4'd7;
  localparam logic [1:0] CPOLPHA_RESET = 2'd0;
  localparam logic [CTRL_W-1:0] CTRL_RESET = {3'b000, LEN_RESET, CPOLPHA_RESET, 1'b0};

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_TXDATA,
    SEL_RXDATA
  } reg_sel_e;

  // Keeps bits 0..len of a received word, clears everything above
  function automatic logic [15:0] len_mask(input logic [3:0] len);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) begin
      m[i] = (i <= int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_fifo.sv
// sync_fifo
//   Single-clock FIFO used for both the TX and RX queues of the SPI slave
//   controller. A push and a pop in the same cycle are both carried out; a
//   pop of an empty FIFO does nothing, and a push into a full FIFO only
//   succeeds when a pop frees the slot in the same cycle. The head word is
//   presented combinationally and reads 0 while the FIFO is empty.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   flush          discard all contents (wins over a same-cycle push)
//   push, wdata    write request and data
//   pop            read request (advances the head)
//   rdata          current head, 0 when empty
//   count          occupancy, 0..DEPTH
//   full, empty    occupancy flags
module sync_fifo
  import spi_slave_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop is real only when there is something to pop; a push into a full
  // FIFO is accepted only if that real pop makes room in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointers and count; pointers are log2(DEPTH) bits and wrap on overflow
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone decide what is valid
  always_ff @(posedge clk) begin
    if (rstn && !flush && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
//   Register-mapped controller for the SPI slave datapath. Owns the TX and
//   RX FIFOs, drives the slave's mode and word length, holds the slave in
//   reset while disabled, and raises a level interrupt.
//   Optional feature macro: SPI_SLAVE_CTRL_IRQ_EN. When defined, the IE
//   bits in CTRL and the interrupt logic exist; otherwise o_irq is 0 and
//   CTRL[9:7] read 0.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   i_addr, i_wr, i_rd   register bus address and one-cycle strobes
//   i_wdata, o_rdata     bus write data, registered read data
//   o_irq                level interrupt
//   o_spi_rstn           reset to the slave datapath (registered rstn & EN)
//   o_CPolPha, o_LEN     SPI mode and word length minus 1
//   o_dataTX, i_rd_TX    TX head to shift out, consume pulse
//   i_wr_RX, i_dataRX    received-word pulse and data
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] i_addr,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata,
  output logic          o_irq,
  output logic          o_spi_rstn,
  output logic [1:0]    o_CPolPha,
  output logic [3:0]    o_LEN,
  output logic [15:0]   o_dataTX,
  input  logic          i_rd_TX,
  input  logic          i_wr_RX,
  input  logic [15:0]   i_dataRX
);

  logic [CTRL_W-1:0] ctrl;
  logic [CTRL_W-1:0] ctrl_next;
  logic              rx_ovf;
  logic              tx_unf;
  logic              rx_ovf_next;
  logic              tx_unf_next;
  reg_sel_e          sel;

  logic              en;
  logic [3:0]        len;
  logic              ctrl_wr;
  logic              status_wr;
  logic              flush;
  logic              tx_push;
  logic              tx_pop_req;
  logic              rx_push_req;
  logic              rx_pop;
  logic              rx_ovf_set;
  logic              tx_unf_set;

  logic [15:0]       rx_head;
  logic [15:0]       rx_wdata;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;

  logic [31:0]       status;
  logic [31:0]       rdata_next;
  logic              irq_next;

  assign en  = ctrl[CTRL_EN];
  assign len = ctrl[CTRL_LEN_LSB +: 4];

  // Address decode into a register select
  always_comb begin
    sel = SEL_NONE;
    if (i_addr == AW'(REG_CTRL))        sel = SEL_CTRL;
    else if (i_addr == AW'(REG_STATUS)) sel = SEL_STATUS;
    else if (i_addr == AW'(REG_TXDATA)) sel = SEL_TXDATA;
    else if (i_addr == AW'(REG_RXDATA)) sel = SEL_RXDATA;
  end

  assign ctrl_wr   = i_wr & (sel == SEL_CTRL);
  assign status_wr = i_wr & (sel == SEL_STATUS);
  assign tx_push   = i_wr & (sel == SEL_TXDATA);
  assign rx_pop    = i_rd & (sel == SEL_RXDATA);

  // Only a write that actually turns EN off flushes; it overrides any push
  // landing in the same cycle because the FIFOs give flush priority.
  assign flush = ctrl_wr & en & ~i_wdata[CTRL_EN];

  // The slave side is ignored while disabled
  assign tx_pop_req  = i_rd_TX & en;
  assign rx_push_req = i_wr_RX & en;

  // A full RX FIFO still accepts a word if the bus pops in the same cycle
  assign rx_ovf_set = rx_push_req & rx_full & ~rx_pop;
  assign tx_unf_set = tx_pop_req & tx_empty;

  assign rx_wdata = i_dataRX & len_mask(len);

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (tx_push),
    .wdata (i_wdata[15:0]),
    .pop   (tx_pop_req),
    .rdata (o_dataTX),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (rx_push_req),
    .wdata (rx_wdata),
    .pop   (rx_pop),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // CTRL update: mode and length are frozen while the slave is enabled
  always_comb begin
    ctrl_next = ctrl;
    if (ctrl_wr) begin
      ctrl_next[CTRL_EN] = i_wdata[CTRL_EN];
      if (!en) begin
        ctrl_next[CTRL_LEN_LSB+3:CTRL_CPOLPHA_LSB] = i_wdata[CTRL_LEN_LSB+3:CTRL_CPOLPHA_LSB];
      end
`ifdef SPI_SLAVE_CTRL_IRQ_EN
      ctrl_next[CTRL_IE_ERR:CTRL_IE_RX] = i_wdata[CTRL_IE_ERR:CTRL_IE_RX];
`endif
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_comb begin
    rx_ovf_next = (rx_ovf & ~(status_wr & i_wdata[ST_RX_OVF])) | rx_ovf_set;
    tx_unf_next = (tx_unf & ~(status_wr & i_wdata[ST_TX_UNF])) | tx_unf_set;
  end

  always_comb begin
    status = '0;
    status[ST_RX_COUNT_LSB +: CNT_W] = rx_count;
    status[ST_TX_COUNT_LSB +: CNT_W] = tx_count;
    status[ST_RX_EMPTY]              = rx_empty;
    status[ST_RX_FULL]               = rx_full;
    status[ST_TX_EMPTY]              = tx_empty;
    status[ST_TX_FULL]               = tx_full;
    status[ST_RX_OVF]                = rx_ovf;
    status[ST_TX_UNF]                = tx_unf;
  end

  // Read mux; RXDATA returns the head, which is already 0 when empty
  always_comb begin
    rdata_next = '0;
    case (sel)
      SEL_CTRL:   rdata_next = 32'(ctrl);
      SEL_STATUS: rdata_next = status;
      SEL_RXDATA: rdata_next = {16'h0000, rx_head};
      default:    rdata_next = '0;
    endcase
  end

  always_comb begin
    irq_next = 1'b0;
`ifdef SPI_SLAVE_CTRL_IRQ_EN
    irq_next = (ctrl[CTRL_IE_RX]  & ~rx_empty) |
               (ctrl[CTRL_IE_TXE] & tx_empty & en) |
               (ctrl[CTRL_IE_ERR] & (rx_ovf | tx_unf));
`endif
  end

  // Register state and the registered outputs. o_spi_rstn follows EN one
  // cycle late; the reset branch supplies the rstn term.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl       <= CTRL_RESET;
      rx_ovf     <= 1'b0;
      tx_unf     <= 1'b0;
      o_rdata    <= '0;
      o_irq      <= 1'b0;
      o_spi_rstn <= 1'b0;
      o_CPolPha  <= CPOLPHA_RESET;
      o_LEN      <= LEN_RESET;
    end else begin
      ctrl       <= ctrl_next;
      rx_ovf     <= rx_ovf_next;
      tx_unf     <= tx_unf_next;
      if (i_rd) o_rdata <= rdata_next;
      o_irq      <= irq_next;
      o_spi_rstn <= en;
      o_CPolPha  <= ctrl[CTRL_CPOLPHA_LSB +: 2];
      o_LEN      <= len;
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl
//   Directed bench for spi_slave_ctrl with DEPTH=8, AW=4. Expected values
//   are hand-computed constants. Works with or without
//   SPI_SLAVE_CTRL_IRQ_EN; the interrupt expectations follow the macro.
// Ports: none (top-level bench).
module tb_spi_slave_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_TXDATA = 4'h8;
  localparam logic [3:0] A_RXDATA = 4'hC;

`ifdef SPI_SLAVE_CTRL_IRQ_EN
  localparam logic        IRQ_ON      = 1'b1;
  localparam logic [31:0] CTRL_IE_VAL = 32'h9D;
`else
  localparam logic        IRQ_ON      = 1'b0;
  localparam logic [31:0] CTRL_IE_VAL = 32'h1D;
`endif

  logic          clk;
  logic          rstn;
  logic [AW-1:0] i_addr;
  logic          i_wr;
  logic          i_rd;
  logic [31:0]   i_wdata;
  logic [31:0]   o_rdata;
  logic          o_irq;
  logic          o_spi_rstn;
  logic [1:0]    o_CPolPha;
  logic [3:0]    o_LEN;
  logic [15:0]   o_dataTX;
  logic          i_rd_TX;
  logic          i_wr_RX;
  logic [15:0]   i_dataRX;

  int errors;
  int checks;
  logic [31:0] rd;

  spi_slave_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_addr     (i_addr),
    .i_wr       (i_wr),
    .i_rd       (i_rd),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_irq      (o_irq),
    .o_spi_rstn (o_spi_rstn),
    .o_CPolPha  (o_CPolPha),
    .o_LEN      (o_LEN),
    .o_dataTX   (o_dataTX),
    .i_rd_TX    (i_rd_TX),
    .i_wr_RX    (i_wr_RX),
    .i_dataRX   (i_dataRX)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs from a falling edge; returns on the falling
  // edge after the rising edge that sampled them
  task automatic applyStimulus(input logic wr, input logic rdq, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic rd_tx,
                               input logic wr_rx, input logic [15:0] data_rx);
    @(negedge clk);
    i_wr     = wr;
    i_rd     = rdq;
    i_addr   = addr;
    i_wdata  = wdata;
    i_rd_TX  = rd_tx;
    i_wr_RX  = wr_rx;
    i_dataRX = data_rx;
    @(negedge clk);
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_rd_TX = 1'b0;
    i_wr_RX = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b0, 1'b0, 16'h0);
    data = o_rdata;
  endtask

  task automatic rx_word(input logic [15:0] d);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, d);
  endtask

  task automatic tx_pop();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rstn     = 1'b0;
    i_addr   = '0;
    i_wr     = 1'b0;
    i_rd     = 1'b0;
    i_wdata  = '0;
    i_rd_TX  = 1'b0;
    i_wr_RX  = 1'b0;
    i_dataRX = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    $display("[TB] reset values");
    checkOutput("rst_rdata", o_rdata, 32'h0);
    checkOutput("rst_irq", 32'(o_irq), 32'h0);
    checkOutput("rst_spi_rstn", 32'(o_spi_rstn), 32'h0);
    checkOutput("rst_cpolpha", 32'(o_CPolPha), 32'h0);
    checkOutput("rst_len", 32'(o_LEN), 32'h7);
    checkOutput("rst_dataTX", 32'(o_dataTX), 32'h0);
    bus_read(A_CTRL, rd);
    checkOutput("rst_ctrl", rd, 32'h38);
    bus_read(A_STATUS, rd);
    checkOutput("rst_status", rd, 32'h1400);

    $display("[TB] enable and TX path");
    bus_write(A_CTRL, 32'h39);
    checkOutput("spi_rstn_lag", 32'(o_spi_rstn), 32'h0);
    @(negedge clk);
    checkOutput("spi_rstn_on", 32'(o_spi_rstn), 32'h1);
    bus_write(A_TXDATA, 32'hA5);
    checkOutput("tx_head_a5", 32'(o_dataTX), 32'hA5);
    bus_write(A_TXDATA, 32'h3C);
    bus_read(A_STATUS, rd);
    checkOutput("status_tx2", rd, 32'h440);
    bus_read(A_TXDATA, rd);
    checkOutput("txdata_read0", rd, 32'h0);
    bus_read(4'h2, rd);
    checkOutput("unmapped_read0", rd, 32'h0);
    tx_pop();
    checkOutput("tx_head_3c", 32'(o_dataTX), 32'h3C);
    tx_pop();
    checkOutput("tx_head_empty", 32'(o_dataTX), 32'h0);
    tx_pop();
    bus_read(A_STATUS, rd);
    checkOutput("status_tx_unf", rd, 32'h9400);
    bus_write(A_STATUS, 32'h8000);
    bus_read(A_STATUS, rd);
    checkOutput("status_unf_clr", rd, 32'h1400);

    $display("[TB] RX path");
    rx_word(16'hFFFF);
    bus_read(A_RXDATA, rd);
    checkOutput("rx_mask_len7", rd, 32'h00FF);
    @(negedge clk);
    checkOutput("rdata_hold", o_rdata, 32'h00FF);
    for (int i = 0; i <= DEPTH; i++) begin
      rx_word(16'(16'h10 + i));
    end
    bus_read(A_STATUS, rd);
    checkOutput("status_rx_ovf", rd, 32'h5808);
    bus_write(A_STATUS, 32'h4000);
    applyStimulus(1'b0, 1'b1, A_RXDATA, 32'h0, 1'b0, 1'b1, 16'h99);
    checkOutput("rx_simul_head", o_rdata, 32'h10);
    bus_read(A_STATUS, rd);
    checkOutput("status_rx_simul", rd, 32'h1808);
    for (int i = 1; i < DEPTH; i++) begin
      bus_read(A_RXDATA, rd);
      checkOutput($sformatf("rx_order_%0d", i), rd, 32'(32'h10 + i));
    end
    bus_read(A_RXDATA, rd);
    checkOutput("rx_last_99", rd, 32'h99);
    bus_read(A_RXDATA, rd);
    checkOutput("rx_empty_read0", rd, 32'h0);

    $display("[TB] simultaneous TX push/pop on empty");
    applyStimulus(1'b1, 1'b0, A_TXDATA, 32'h77, 1'b1, 1'b0, 16'h0);
    checkOutput("tx_simul_head", 32'(o_dataTX), 32'h77);
    bus_read(A_STATUS, rd);
    checkOutput("status_tx_simul", rd, 32'h8420);

    $display("[TB] CTRL lock and flush");
    bus_write(A_TXDATA, 32'h55);
    rx_word(16'h1234);
    bus_write(A_CTRL, 32'h79);
    bus_read(A_CTRL, rd);
    checkOutput("ctrl_locked", rd, 32'h39);
    checkOutput("len_locked", 32'(o_LEN), 32'h7);
    bus_write(A_CTRL, 32'h38);
    checkOutput("spi_rstn_off_lag", 32'(o_spi_rstn), 32'h1);
    @(negedge clk);
    checkOutput("spi_rstn_off", 32'(o_spi_rstn), 32'h0);
    checkOutput("flush_dataTX", 32'(o_dataTX), 32'h0);
    bus_read(A_STATUS, rd);
    checkOutput("status_flushed", rd, 32'h9400);
    bus_write(A_STATUS, 32'h8000);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 16'h1);
    bus_read(A_STATUS, rd);
    checkOutput("status_disabled_ignored", rd, 32'h1400);

    $display("[TB] mode and length");
    bus_write(A_CTRL, 32'h1C);
    checkOutput("len_lag", 32'(o_LEN), 32'h7);
    @(negedge clk);
    checkOutput("len_3", 32'(o_LEN), 32'h3);
    checkOutput("cpolpha_2", 32'(o_CPolPha), 32'h2);
    bus_write(A_CTRL, 32'h1D);
    rx_word(16'hABCD);
    bus_read(A_RXDATA, rd);
    checkOutput("rx_mask_len3", rd, 32'h000D);

    $display("[TB] interrupt");
    bus_write(A_CTRL, 32'h9D);
    bus_read(A_CTRL, rd);
    checkOutput("ctrl_ie", rd, CTRL_IE_VAL);
    rx_word(16'h5A);
    checkOutput("irq_lag", 32'(o_irq), 32'h0);
    @(negedge clk);
    checkOutput("irq_rx", 32'(o_irq), 32'(IRQ_ON));
    bus_read(A_RXDATA, rd);
    checkOutput("rx_irq_word", rd, 32'hA);
    checkOutput("irq_hold", 32'(o_irq), 32'(IRQ_ON));
    @(negedge clk);
    checkOutput("irq_clear", 32'(o_irq), 32'h0);

    $display("[TB] reset mid-transfer");
    bus_write(A_TXDATA, 32'h42);
    checkOutput("pre_reset_head", 32'(o_dataTX), 32'h42);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("mid_rst_dataTX", 32'(o_dataTX), 32'h0);
    checkOutput("mid_rst_len", 32'(o_LEN), 32'h7);
    checkOutput("mid_rst_spi_rstn", 32'(o_spi_rstn), 32'h0);
    bus_read(A_STATUS, rd);
    checkOutput("mid_rst_status", rd, 32'h1400);
    bus_read(A_CTRL, rd);
    checkOutput("mid_rst_ctrl", rd, 32'h38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Register-mapped controller that sequences the SPI slave datapath. It owns the slave's TX and RX FIFOs, drives its mode (`CPolPha`) and word length (`LEN`), holds it in reset while disabled, and raises an interrupt to the CPU. It sits between the SoC peripheral bus and the SPI slave shifter, all in the `clk` domain.

## Interface
Parameters:
- `DEPTH`, 8: entries per FIFO; power of two, minimum 2.
- `AW`, 4: byte-address width of the register window.

Ports:
- `clk`, in, 1: system clock. One clock; everything is synchronous to it.
- `rstn`, in, 1: reset, synchronous and active-low.
- `i_addr`, in, AW: register byte address, word aligned.
- `i_wr`, in, 1: write strobe, one cycle.
- `i_rd`, in, 1: read strobe, one cycle.
- `i_wdata`, in, 32: write data.
- `o_rdata`, out, 32: read data, registered.
- `o_irq`, out, 1: level interrupt.
- `o_spi_rstn`, out, 1: reset to the slave datapath.
- `o_CPolPha`, out, 2: SPI mode.
- `o_LEN`, out, 4: word length minus 1.
- `o_dataTX`, out, 16: word presented to the slave for shifting out.
- `i_rd_TX`, in, 1: slave consumed `o_dataTX`; one-cycle pulse.
- `i_wr_RX`, in, 1: slave has a received word; one-cycle pulse.
- `i_dataRX`, in, 16: received word, valid with `i_wr_RX`.

## Operation
**Registers**
- 0x0 CTRL: [0] EN, [2:1] CPOLPHA, [6:3] LEN, [7] IE_RX, [8] IE_TXE, [9] IE_ERR.
  - While EN=1, writes to bits 6:1 are ignored.
- 0x4 STATUS, read-only except the sticky bits:
  - [4:0] rx_count, [9:5] tx_count, [10] rx_empty, [11] rx_full, [12] tx_empty, [13] tx_full.
  - [14] rx_ovf and [15] tx_unf are sticky; write 1 to clear.
- 0x8 TXDATA: a write pushes `i_wdata[15:0]`. Reads return 0.
- 0xC RXDATA: a read returns the RX head and pops it. Writes are ignored.
- Unmapped addresses read 0.

**Data path**
- `o_dataTX` equals the TX head, or 0 when the TX FIFO is empty.
- `i_rd_TX` pops the TX head. If the FIFO is empty, nothing is popped and tx_unf is set.
- `i_wr_RX` pushes `i_dataRX` masked to its low LEN+1 bits; bits above LEN read 0.
  - If the RX FIFO is full, the word is dropped, the FIFO contents are unchanged, and rx_ovf is set.
- Bus push to a full TX FIFO: dropped, no flag.
- RXDATA read of an empty RX FIFO: returns 0 and pops nothing.

**Enable and flush**
- `o_spi_rstn` = registered (rstn & EN).
- A 1→0 transition of EN flushes both FIFOs. Counts become 0; sticky flags are kept.
- While EN=0, `i_rd_TX` and `i_wr_RX` are ignored.

**Simultaneous events**
- TX: bus push and `i_rd_TX` in the same cycle are both performed; the count is unchanged.
  - If the FIFO was empty, the pop sees empty: tx_unf is set and the pushed word stays.
- RX: `i_wr_RX` and an RXDATA read in the same cycle are both performed.
  - If the FIFO was full, the pop frees the slot and the push succeeds; no rx_ovf.
- Write of EN=0 together with a pending push: the flush wins.

**IRQ**
- `o_irq` = (IE_RX & !rx_empty) | (IE_TXE & tx_empty & EN) | (IE_ERR & (rx_ovf|tx_unf)), registered.

## Timing
- `o_rdata` is valid the cycle after `i_rd`, and holds until the next read.
- The pop on an RXDATA read takes effect at the same edge that captures `o_rdata`.
- Register writes take effect at the strobe edge. `o_CPolPha`, `o_LEN` and `o_spi_rstn` update one cycle later.
- FIFO push → count, flags and `o_dataTX`: visible the next cycle.
- `o_irq` lags its source by 1 cycle.
- Reset values:
  - Outputs: `o_rdata`=0, `o_irq`=0, `o_spi_rstn`=0, `o_CPolPha`=0, `o_LEN`=7, `o_dataTX`=0.
  - Internal: all FIFOs empty, flags 0, CTRL=0x38.
- Reset asserted mid-transfer: state returns to the reset values at the next edge; FIFO contents are discarded.
- Counts are 5 bits, so DEPTH ≤ 16. Pointers are log2(DEPTH) bits and wrap naturally.

## Configuration
- `SPI_SLAVE_CTRL_IRQ_EN` defined: the IRQ logic and IE bits are implemented as above.
- Undefined:
  - `o_irq` is tied to 0.
  - CTRL bits [9:7] read 0 and ignore writes.
  - The sticky flags still operate.

## Structure
- Package `spi_slave_ctrl_pkg`:
  - Register offsets: `REG_CTRL`, `REG_STATUS`, `REG_TXDATA`, `REG_RXDATA`.
  - CTRL and STATUS bit-position constants.
  - `LEN_RESET` = 4'd7.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH), instantiated twice for TX and RX.
  - Push/pop with simultaneous-operation support, count, full and empty outputs.

## Test plan
- Reset, then read CTRL, STATUS and `o_rdata` → 0x38, tx_empty=1, rx_empty=1, counts 0, all outputs at their reset values.
- Write CTRL=0x39 (EN, LEN=7), push 0xA5 and 0x3C, pulse `i_rd_TX` → `o_dataTX` goes 0xA5, then 0x3C, then 0; a third pulse sets tx_unf.
- Pulse `i_wr_RX` with `i_dataRX`=0xFFFF at LEN=7 → RXDATA reads 0x00FF. Fill DEPTH+1 words → rx_ovf=1 and the first DEPTH words read back in order.
- With the RX FIFO full, assert `i_wr_RX` and an RXDATA read in the same cycle → no rx_ovf, count stays DEPTH.
- While EN=1, write CTRL with LEN=15 → LEN stays 7. Write EN=0 → both FIFOs flushed and `o_spi_rstn`=0 one cycle later.
- With the macro defined, set IE_RX and push one RX word → `o_irq`=1 two cycles after the pulse, and 0 after the RXDATA read.
